fifo_tx_feeder: RTL

FIFO_TX_FEEDER -- requirements
Module: fifo_tx_feeder

---
 rtl/fifo_tx_feeder_pkg.sv | 14 +
 rtl/feeder_timeout_cnt.sv | 28 ++
 rtl/fifo_tx_feeder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fifo_tx_feeder_pkg.sv
// Shared definitions for the FIFO-to-transmitter feeder: FSM encoding and default sizes.
package fifo_tx_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } feeder_state_t;

    localparam int TIMEOUT_DEFAULT = 16;
    localparam int SENT_CNT_W      = 16;

endpackage

// File: rtl/feeder_timeout_cnt.sv
// Loadable down-counter; done marks the last cycle of the timeout window.
module feeder_timeout_cnt #(
    parameter int CNT_W = 5
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    // Loaded with the full window length, so a value of one is the final waiting cycle.
    assign done = en && (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/fifo_tx_feeder.sv
// Pops words from a FIFO into a one-word stage and hands them to a byte transmitter
// using a send pulse followed by a busy-high / busy-low handshake with timeout.
module fifo_tx_feeder
    import fifo_tx_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  enable,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    input  logic                  tx_busy,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  err_timeout,
    output logic [SENT_CNT_W-1:0] sent_cnt
);

    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT);

    feeder_state_t state_reg, state_next;

    logic [DATA_WIDTH-1:0] stage_data_reg;
    logic                  stage_valid_reg;
    logic [DATA_WIDTH-1:0] tx_data_reg;
    logic                  tx_valid_reg;
    logic                  err_timeout_reg;
    logic [SENT_CNT_W-1:0] sent_cnt_reg;

    logic stage_take;
    logic to_load;
    logic to_en;
    logic to_done;
    logic err_set;

    feeder_timeout_cnt #(
        .CNT_W (TO_W)
    ) u_timeout_cnt (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .load     (to_load),
        .load_val (TO_LOAD),
        .en       (to_en),
        .done     (to_done)
    );

    // rinc is qualified by reset so the FIFO is never popped while the feeder is held.
    always_comb begin
        stage_take = (state_reg == ST_IDLE) && stage_valid_reg && !tx_busy && enable;
        rinc       = rrst_n && enable && !rempty && (!stage_valid_reg || stage_take);
    end

    always_comb begin
        state_next = state_reg;
        to_load    = 1'b0;
        to_en      = 1'b0;
        err_set    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (stage_take) begin
                    state_next = ST_PULSE;
                end
            end
            ST_PULSE: begin
                to_load    = 1'b1;
                state_next = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                to_en = 1'b1;
                if (tx_busy) begin
                    state_next = ST_WAIT_LO;
                end else if (to_done) begin
                    err_set    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_reg       <= ST_IDLE;
            stage_data_reg  <= '0;
            stage_valid_reg <= 1'b0;
            tx_data_reg     <= '0;
            tx_valid_reg    <= 1'b0;
            err_timeout_reg <= 1'b0;
            sent_cnt_reg    <= '0;
        end else begin
            state_reg <= state_next;
            // A pop in the same cycle as a take refills the stage back-to-back.
            if (rinc) begin
                stage_data_reg  <= rdata;
                stage_valid_reg <= 1'b1;
            end else if (stage_take) begin
                stage_valid_reg <= 1'b0;
            end
            if (stage_take) begin
                tx_data_reg <= stage_data_reg;
            end
            tx_valid_reg <= (state_next == ST_PULSE);
            if (state_reg == ST_PULSE) begin
                sent_cnt_reg <= sent_cnt_reg + SENT_CNT_W'(1);
            end
            if (err_set) begin
                err_timeout_reg <= 1'b1;
            end
        end
    end

    assign tx_data     = tx_data_reg;
    assign tx_valid    = tx_valid_reg;
    assign err_timeout = err_timeout_reg;
    assign sent_cnt    = sent_cnt_reg;

endmodule
